// File: rtl/pon_burst_scheduler.sv
// Round-robin upstream TDMA burst scheduler that loads and gates a PON burst generator.
// Define BURST_SCHED_STATS_EN to build the burst/beat statistics counters.
module pon_burst_scheduler #(
  parameter int NUM_ONU        = 4,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     tx_axis_usrclk,
  input  logic                     reset_in,
  input  logic [NUM_ONU-1:0]       req_valid,
  input  logic [NUM_ONU*LEN_W-1:0] req_len,
  output logic [NUM_ONU-1:0]       gnt,
  input  logic [31:0]              cfg_preamble_length,
  input  logic [15:0]              cfg_guard_cycles,
  output logic                     gen_enable,
  output logic [31:0]              gen_preamble_length,
  output logic [31:0]              gen_burst_length,
  output logic [31:0]              gen_burst_period,
  input  logic                     mon_tvalid,
  input  logic                     mon_tready,
  input  logic                     mon_tlast,
  output logic [3:0]               active_onu,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     err_zero_len,
  output logic [31:0]              burst_count,
  output logic [31:0]              beat_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_RUN,
    S_GUARD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        rr_ptr;
  logic [CNT_W-1:0]  run_cnt;
  logic [15:0]       guard_cnt;
  logic [4:0]        pick;
  logic              win_found;
  logic [3:0]        win_idx;
  logic [LEN_W-1:0]  win_len;
  logic [LEN_W-1:0]  len_arr [16];
  logic              beat;
  logic              last_beat;

  // First requester at or after ptr (with wrap); returns {found, index}.
  function automatic logic [4:0] rr_pick(input logic [NUM_ONU-1:0] req,
                                         input logic [3:0]         ptr);
    logic [15:0] req16;
    logic [4:0]  sum;
    logic [4:0]  res;
    req16 = 16'(req);
    res   = '0;
    for (int j = NUM_ONU - 1; j >= 0; j--) begin
      sum = {1'b0, ptr} + 5'(j);
      if (sum >= 5'(NUM_ONU)) sum = sum - 5'(NUM_ONU);
      if (req16[sum[3:0]]) res = {1'b1, sum[3:0]};
    end
    return res;
  endfunction

  function automatic logic [3:0] rr_advance(input logic [3:0] idx);
    logic [4:0] nxt;
    nxt = {1'b0, idx} + 5'd1;
    if (nxt >= 5'(NUM_ONU)) nxt = '0;
    return nxt[3:0];
  endfunction

  // Period wraps modulo 2^32 by construction.
  function automatic logic [31:0] burst_period(input logic [31:0] pre,
                                               input logic [31:0] len,
                                               input logic [15:0] guard);
    return pre + len + 32'd1 + 32'(guard);
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_len
    if (g < NUM_ONU) begin : g_used
      assign len_arr[g] = req_len[g*LEN_W +: LEN_W];
    end else begin : g_pad
      assign len_arr[g] = '0;
    end
  end

  assign pick      = rr_pick(req_valid, rr_ptr);
  assign win_found = pick[4];
  assign win_idx   = pick[3:0];
  assign win_len   = len_arr[win_idx];
  assign beat      = mon_tvalid & mon_tready;
  assign last_beat = beat & mon_tlast;

  always_ff @(posedge tx_axis_usrclk) begin
    if (reset_in) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    gnt          = '0;
    gen_enable   = 1'b0;
    err_timeout  = 1'b0;
    err_zero_len = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (|req_valid) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (!win_found) begin
          state_nxt = S_IDLE;
        end else begin
          gnt = NUM_ONU'(1) << win_idx;
          if (win_len == '0) begin
            err_zero_len = 1'b1;
            state_nxt    = S_IDLE;
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        gen_enable = 1'b1;
        if (last_beat) begin
          state_nxt = S_GUARD;
        end else if (run_cnt == RUN_LAST) begin
          err_timeout = 1'b1;
          state_nxt   = S_GUARD;
        end
      end
      S_GUARD: begin
        // A guard of 0 or 1 both leave after a single cycle.
        if (guard_cnt <= 16'd1) state_nxt = (|req_valid) ? S_ARB : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ARB -> LOAD boundary: burst configuration is captured once per grant.
  always_ff @(posedge tx_axis_usrclk) begin
    if (reset_in) begin
      rr_ptr              <= '0;
      active_onu          <= '0;
      gen_preamble_length <= '0;
      gen_burst_length    <= '0;
      gen_burst_period    <= '0;
      run_cnt             <= '0;
      guard_cnt           <= '0;
    end else begin
      if (state == S_ARB && win_found) begin
        active_onu          <= win_idx;
        rr_ptr              <= rr_advance(win_idx);
        gen_preamble_length <= cfg_preamble_length;
        gen_burst_length    <= 32'(win_len);
        gen_burst_period    <= burst_period(cfg_preamble_length, 32'(win_len),
                                            cfg_guard_cycles);
      end
      run_cnt <= (state == S_RUN) ? run_cnt + CNT_W'(1) : '0;
      if (state == S_RUN && state_nxt == S_GUARD) begin
        guard_cnt <= cfg_guard_cycles;
      end else if (state == S_GUARD && guard_cnt != '0) begin
        guard_cnt <= guard_cnt - 16'd1;
      end
    end
  end

`ifdef BURST_SCHED_STATS_EN
  always_ff @(posedge tx_axis_usrclk) begin
    if (reset_in) begin
      burst_count <= '0;
      beat_count  <= '0;
    end else if (state == S_RUN) begin
      if (beat)      beat_count  <= beat_count + 32'd1;
      if (last_beat) burst_count <= burst_count + 32'd1;
    end
  end
`else
  assign burst_count = '0;
  assign beat_count  = '0;
`endif

endmodule

// File: tb/tb_pon_burst_scheduler.sv
// Directed self-checking bench for pon_burst_scheduler (TIMEOUT_CYCLES=20).
module tb_pon_burst_scheduler;
  localparam int NUM_ONU = 4;
  localparam int LEN_W   = 16;
  localparam int TO      = 20;

`ifdef BURST_SCHED_STATS_EN
  localparam logic [31:0] EXP_BURSTS = 32'd3;
  localparam logic [31:0] EXP_BEATS  = 32'd24;
`else
  localparam logic [31:0] EXP_BURSTS = 32'd0;
  localparam logic [31:0] EXP_BEATS  = 32'd0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_ONU-1:0]       req_valid;
  logic [NUM_ONU*LEN_W-1:0] req_len;
  logic [NUM_ONU-1:0]       gnt;
  logic [31:0]              cfg_preamble_length;
  logic [15:0]              cfg_guard_cycles;
  logic                     gen_enable;
  logic [31:0]              gen_preamble_length;
  logic [31:0]              gen_burst_length;
  logic [31:0]              gen_burst_period;
  logic                     mon_tvalid;
  logic                     mon_tready;
  logic                     mon_tlast;
  logic [3:0]               active_onu;
  logic                     busy;
  logic                     err_timeout;
  logic                     err_zero_len;
  logic [31:0]              burst_count;
  logic [31:0]              beat_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  pon_burst_scheduler #(
    .NUM_ONU(NUM_ONU),
    .LEN_W(LEN_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .tx_axis_usrclk(clk),
    .reset_in(rst),
    .req_valid(req_valid),
    .req_len(req_len),
    .gnt(gnt),
    .cfg_preamble_length(cfg_preamble_length),
    .cfg_guard_cycles(cfg_guard_cycles),
    .gen_enable(gen_enable),
    .gen_preamble_length(gen_preamble_length),
    .gen_burst_length(gen_burst_length),
    .gen_burst_period(gen_burst_period),
    .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready),
    .mon_tlast(mon_tlast),
    .active_onu(active_onu),
    .busy(busy),
    .err_timeout(err_timeout),
    .err_zero_len(err_zero_len),
    .burst_count(burst_count),
    .beat_count(beat_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int idx, input logic [LEN_W-1:0] val);
    req_len[idx*LEN_W +: LEN_W] = val;
  endtask

  // Called in RUN cycle 1; returns in the cycle after the accepted TLAST beat.
  task automatic drive_burst(input int nbeats, input bit toggle);
    int acc;
    bit rdy;
    acc = 0;
    rdy = 1'b1;
    while (acc < nbeats) begin
      mon_tvalid = 1'b1;
      mon_tready = rdy;
      mon_tlast  = (acc == nbeats - 1);
      #1;
      if (rdy) acc++;
      if (acc == nbeats) check("burst_last_enable", 32'(gen_enable), 32'd1);
      tick();
      if (toggle) rdy = !rdy;
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic await_grant(output int cycles);
    cycles = 0;
    while (gnt == '0 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst                 = 1'b1;
    req_valid           = '0;
    req_len             = '0;
    cfg_preamble_length = '0;
    cfg_guard_cycles    = '0;
    mon_tvalid          = 1'b0;
    mon_tready          = 1'b0;
    mon_tlast           = 1'b0;
    tick();
    tick();
    check("rst_enable", 32'(gen_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_period", gen_burst_period, 32'd0);
    check("rst_onu", 32'(active_onu), 32'd0);
    check("rst_bursts", burst_count, 32'd0);
    rst = 1'b0;

    // Single requester 1: len 8, preamble 4, guard 10.
    cfg_preamble_length = 32'd4;
    cfg_guard_cycles    = 16'd10;
    set_len(1, 16'd8);
    req_valid = 4'b0010;
    #1;
    check("s1_idle_gnt", 32'(gnt), 32'd0);
    tick();
    check("s1_gnt", 32'(gnt), 32'b0010);
    check("s1_arb_enable", 32'(gen_enable), 32'd0);
    tick();
    req_valid = '0;
    check("s1_load_enable", 32'(gen_enable), 32'd0);
    check("s1_load_gnt", 32'(gnt), 32'd0);
    check("s1_period", gen_burst_period, 32'd23);
    check("s1_length", gen_burst_length, 32'd8);
    check("s1_preamble", gen_preamble_length, 32'd4);
    check("s1_onu", 32'(active_onu), 32'd1);
    tick();
    check("s1_run_enable", 32'(gen_enable), 32'd1);
    drive_burst(8, 1'b0);
    check("s1_enable_drop", 32'(gen_enable), 32'd0);
    check("s1_guard_busy", 32'(busy), 32'd1);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b1;
    wait_idle(cyc);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    check("s1_guard_cycles", 32'(cyc), 32'd10);

    // All four requesting continuously after reset: grants 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_guard_cycles = 16'd2;
    for (int i = 0; i < NUM_ONU; i++) set_len(i, 16'd3);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      await_grant(cyc);
      check($sformatf("s2_gnt_%0d", k), 32'(gnt), 32'd1 << (k % 4));
      if (k > 0) check($sformatf("s2_guard_%0d", k), 32'(cyc), 32'd2);
      tick();
      check($sformatf("s2_onu_%0d", k), 32'(active_onu), 32'(k % 4));
      tick();
      if (k == 4) req_valid = '0;
      drive_burst(3, 1'b0);
    end
    wait_idle(cyc);

    // Zero-length request from requester 2 (pointer is 1).
    set_len(2, 16'd0);
    req_valid = 4'b0100;
    tick();
    check("s3_gnt", 32'(gnt), 32'b0100);
    check("s3_zero_len", 32'(err_zero_len), 32'd1);
    check("s3_arb_enable", 32'(gen_enable), 32'd0);
    tick();
    req_valid = '0;
    check("s3_zero_len_clear", 32'(err_zero_len), 32'd0);
    check("s3_enable", 32'(gen_enable), 32'd0);
    check("s3_busy", 32'(busy), 32'd0);

    // Pointer now 3: requesters 0 and 3 compete, 3 wins; then time out.
    cfg_preamble_length = 32'd7;
    cfg_guard_cycles    = 16'd3;
    set_len(0, 16'd5);
    set_len(3, 16'd5);
    req_valid = 4'b1001;
    tick();
    check("s3_ptr_gnt", 32'(gnt), 32'b1000);
    tick();
    req_valid = '0;
    check("s4_period", gen_burst_period, 32'd16);
    check("s4_onu", 32'(active_onu), 32'd3);
    tick();
    cfg_preamble_length = 32'd99;
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      if (c == 5) begin
        set_len(1, 16'd4);
        req_valid = 4'b0010;
      end
      if (c == TO - 1) check("s4_no_early_timeout", 32'(err_timeout), 32'd0);
      if (c == TO) begin
        check("s4_timeout", 32'(err_timeout), 32'd1);
        check("s4_timeout_enable", 32'(gen_enable), 32'd1);
        check("s4_preamble_held", gen_preamble_length, 32'd7);
      end
      if (c < TO) tick();
    end
    tick();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    check("s4_guard_enable", 32'(gen_enable), 32'd0);
    check("s4_timeout_clear", 32'(err_timeout), 32'd0);
    await_grant(cyc);
    check("s4_next_gnt", 32'(gnt), 32'b0010);
    check("s4_guard_cycles", 32'(cyc), 32'd3);

    // Reset in the middle of requester 1's burst.
    tick();
    req_valid = '0;
    tick();
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("s5_enable", 32'(gen_enable), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_gnt", 32'(gnt), 32'd0);
    check("s5_length", gen_burst_length, 32'd0);
    check("s5_beats", beat_count, 32'd0);
    rst        = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;

    // Three 8-beat bursts with toggling TREADY, guard 0, wrapping period.
    cfg_preamble_length = 32'hFFFF_FFFA;
    cfg_guard_cycles    = 16'd0;
    for (int i = 0; i < NUM_ONU; i++) set_len(i, 16'd8);
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      await_grant(cyc);
      check($sformatf("s6_gnt_%0d", k), 32'(gnt), 32'd1 << k);
      if (k > 0) check($sformatf("s6_guard_%0d", k), 32'(cyc), 32'd1);
      tick();
      if (k == 0) check("s6_period_wrap", gen_burst_period, 32'd3);
      if (k == 2) req_valid = '0;
      tick();
      drive_burst(8, 1'b1);
    end
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b1;
    wait_idle(cyc);
    tick();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    check("s6_idle_enable", 32'(gen_enable), 32'd0);
    check("s6_burst_count", burst_count, EXP_BURSTS);
    check("s6_beat_count", beat_count, EXP_BEATS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
